// File: rtl/gate_pool_driver.sv
// rtl/gate_pool_driver.sv - UART byte-stream front end for the NOT/OR/AND gate pool
module gate_pool_driver #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic [WIDTH-1:0] o_not_in,
    output logic [WIDTH-1:0] o_or_a,
    output logic [WIDTH-1:0] o_or_b,
    output logic [WIDTH-1:0] o_and_a,
    output logic [WIDTH-1:0] o_and_b,
    input  logic [WIDTH-1:0] i_res_not,
    input  logic [WIDTH-1:0] i_res_or,
    input  logic [WIDTH-1:0] i_res_and,
    output logic             o_busy,
    output logic             o_rx_drop,
    output logic             o_timeout
);

    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(NB - 1);
    localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, EXEC, CAPTURE, SEND, ERR
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg, shreg;
    logic [1:0]       opcode;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    tcnt;
    logic             hs, last_lane, tmo_hit, op_ok, drop, tmo;

    assign o_tx_valid = (state == SEND) || (state == ERR);
    assign o_tx_data  = (state == ERR)  ? 8'hEE :
                        (state == SEND) ? shreg[7:0] : 8'h00;
    assign o_busy     = (state != IDLE);
    assign o_not_in   = a_reg;
    assign o_or_a     = a_reg;
    assign o_or_b     = b_reg;
    assign o_and_a    = a_reg;
    assign o_and_b    = b_reg;

    assign hs        = o_tx_valid & i_tx_ready;
    assign last_lane = (cnt == LAST_LANE);
    assign op_ok     = (i_rx_data <= 8'h02);
    assign tmo_hit   = ((state == GET_A) || (state == GET_B)) && !i_rx_valid && (tcnt == TLAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        drop     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE:    if (i_rx_valid) state_nx = op_ok ? GET_A : ERR;
            GET_A: begin
                if (i_rx_valid) begin
                    if (last_lane) state_nx = GET_B;
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                    tmo      = 1'b1;
                end
            end
            GET_B: begin
                if (i_rx_valid) begin
                    if (last_lane) state_nx = EXEC;
                end else if (tmo_hit) begin
                    state_nx = IDLE;
                    tmo      = 1'b1;
                end
            end
            EXEC:    state_nx = CAPTURE;
            CAPTURE: state_nx = SEND;
            SEND:    if (hs && last_lane) state_nx = IDLE;
            ERR:     if (hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Bytes arriving while the result path owns the block are discarded.
        if (i_rx_valid && (state == EXEC || state == CAPTURE || state == SEND || state == ERR))
            drop = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            shreg     <= '0;
            opcode    <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            o_rx_drop <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_rx_drop <= drop;
            o_timeout <= tmo;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    tcnt <= '0;
                    if (i_rx_valid && op_ok) opcode <= i_rx_data[1:0];
                end
                GET_A, GET_B: begin
                    if (i_rx_valid) begin
                        if (state == GET_A) a_reg[{cnt, 3'b000} +: 8] <= i_rx_data;
                        else                b_reg[{cnt, 3'b000} +: 8] <= i_rx_data;
                        cnt  <= last_lane ? '0 : cnt + 1'b1;
                        tcnt <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    cnt <= '0;
                    case (opcode)
                        2'd0:    shreg <= i_res_not;
                        2'd1:    shreg <= i_res_or;
                        default: shreg <= i_res_and;
                    endcase
                end
                SEND: begin
                    if (hs) begin
                        shreg <= shreg >> 8;
                        cnt   <= last_lane ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_pool_driver.sv
// tb/tb_gate_pool_driver.sv - self-checking bench for gate_pool_driver
module tb_gate_pool_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] not_in, or_a, or_b, and_a, and_b;
    logic [31:0] res_not, res_or, res_and;
    logic        busy, rx_drop, timeout;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign res_not = ~not_in;
    assign res_or  = or_a | or_b;
    assign res_and = and_a & and_b;

    gate_pool_driver #(.WIDTH(32), .TIMEOUT_CYC(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_not_in(not_in), .o_or_a(or_a), .o_or_b(or_b), .o_and_a(and_a), .o_and_b(and_b),
        .i_res_not(res_not), .i_res_or(res_or), .i_res_and(res_and),
        .o_busy(busy), .o_rx_drop(rx_drop), .o_timeout(timeout)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        int          nbytes;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int gap_max);
        send_byte(op);
        if (op <= 8'h02) begin
            for (int i = 0; i < 4; i++) begin
                idle($urandom_range(0, gap_max));
                send_byte(a[8*i +: 8]);
            end
            for (int i = 0; i < 4; i++) begin
                idle($urandom_range(0, gap_max));
                send_byte(b[8*i +: 8]);
            end
        end
    endtask

    // mode 0: always ready; 1: stalled 5 cycles then alternating; 2: random ready
    task automatic drain(input int mode, input int max_bytes);
        int c = 0;
        logic stalled = 1'b0;
        logic [7:0] held = 8'h00;
        logic rdy;
        got.delete();
        while (got.size() < max_bytes && c < 2000) begin
            if (stalled && tx_valid) check("tx_hold", tx_data, held);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c >= 5) && (c % 2 == 1);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            if (tx_valid && rdy) got.push_back(tx_data);
            stalled = tx_valid && !rdy;
            held    = tx_data;
            c++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("drain_budget", 64'(got.size() >= max_bytes), 64'd1);
    endtask

    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        exp_q.delete();
        if (op > 8'h02) begin
            exp_q.push_back(8'hEE);
        end else begin
            r = (op == 8'h00) ? ~a : (op == 8'h01) ? (a | b) : (a & b);
            for (int i = 0; i < 4; i++) exp_q.push_back(8'((r >> (8 * i)) & 32'hFF));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check({name, "_tx_data"},  64'(tx_data), 64'd0);
        check({name, "_busy"},     64'(busy), 64'd0);
        check({name, "_rx_drop"},  64'(rx_drop), 64'd0);
        check({name, "_timeout"},  64'(timeout), 64'd0);
        check({name, "_a"},        64'(not_in), 64'd0);
        check({name, "_b"},        64'(or_b), 64'd0);
    endtask

    initial begin
        int seen;
        logic [7:0]  rop;
        logic [31:0] ra, rb;

        vecs[0] = '{8'h00, 32'h12345678, 32'h00000000, 0, 4, 32'hEDCBA987};
        vecs[1] = '{8'h01, 32'h0000000F, 32'h010000F0, 1, 4, 32'h010000FF};
        vecs[2] = '{8'h02, 32'h0000FFFF, 32'h0F0F0F0F, 0, 4, 32'h00000F0F};
        vecs[3] = '{8'h07, 32'h0,        32'h0,        0, 1, 32'h000000EE};

        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].op, vecs[v].a, vecs[v].b, 0);
            if (vecs[v].op <= 8'h02) begin
                check("lat_n1", 64'(tx_valid), 64'd0);
                @(negedge clk);
                check("lat_n2", 64'(tx_valid), 64'd0);
                @(negedge clk);
                check("lat_n3", 64'(tx_valid), 64'd1);
                check("op_a", 64'(not_in), 64'(vecs[v].a));
                check("op_and_a", 64'(and_a), 64'(vecs[v].a));
                check("op_b", 64'(or_b), 64'(vecs[v].b));
                check("op_and_b", 64'(and_b), 64'(vecs[v].b));
            end
            drain(vecs[v].mode, vecs[v].nbytes);
            for (int i = 0; i < vecs[v].nbytes; i++)
                check($sformatf("vec%0d_byte%0d", v, i), 64'(got[i]), 64'(vecs[v].exp[8*i +: 8]));
            check("end_busy", 64'(busy), 64'd0);
            check("end_valid", 64'(tx_valid), 64'd0);
            idle(2);
        end

        // Invalid opcode with an extra byte arriving during ERR.
        send_byte(8'h07);
        check("err_valid", 64'(tx_valid), 64'd1);
        check("err_data", 64'(tx_data), 64'hEE);
        send_byte(8'h00);
        check("err_drop", 64'(rx_drop), 64'd1);
        @(negedge clk);
        check("err_drop_end", 64'(rx_drop), 64'd0);
        drain(0, 1);
        check("err_byte", 64'(got[0]), 64'hEE);
        seen = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid || busy) seen++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("err_no_second", 64'(seen), 64'd0);

        // Inter-byte timeout, then a clean OR frame.
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 1; i <= 18; i++) begin
            if (i == 17) begin
                check("tmo_pulse", 64'(timeout), 64'd1);
                check("tmo_idle", 64'(busy), 64'd0);
            end else begin
                check($sformatf("tmo_quiet%0d", i), 64'(timeout), 64'd0);
            end
            if (i == 16) check("tmo_busy_before", 64'(busy), 64'd1);
            @(negedge clk);
        end
        check("tmo_partial_a", 64'(or_a[15:0]), 64'h2211);
        send_frame(8'h01, 32'h00000001, 32'h00000002, 0);
        drain(0, 4);
        model(8'h01, 32'h00000001, 32'h00000002);
        for (int i = 0; i < 4; i++) check($sformatf("post_tmo_byte%0d", i), 64'(got[i]), 64'(exp_q[i]));

        // Reset in the middle of SEND.
        send_frame(8'h00, 32'hA5A5_0F0F, 32'h0, 0);
        drain(0, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) seen++;
            @(negedge clk);
        end
        tx_ready = 1'b0;
        check("midreset_no_tx", 64'(seen), 64'd0);
        send_frame(8'h00, 32'h12345678, 32'h0, 0);
        drain(0, 4);
        model(8'h00, 32'h12345678, 32'h0);
        for (int i = 0; i < 4; i++) check($sformatf("post_rst_byte%0d", i), 64'(got[i]), 64'(exp_q[i]));

        // Random frames against the reference model.
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0:       rop = 8'h00;
                1:       rop = 8'h01;
                2:       rop = 8'h02;
                default: rop = 8'($urandom_range(3, 255));
            endcase
            ra = $urandom;
            rb = $urandom;
            send_frame(rop, ra, rb, 3);
            model(rop, ra, rb);
            drain(2, exp_q.size());
            for (int i = 0; i < exp_q.size(); i++)
                check($sformatf("rnd%0d_byte%0d", t, i), 64'(got[i]), 64'(exp_q[i]));
            check("rnd_idle", 64'(busy), 64'd0);
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_pool_driver.md
Name: gate_pool_driver

Overview:
- Byte-stream front end for the gate pool on the debug UART path.
- Accepts command frames from the UART receiver byte interface: opcode, operand A, operand B.
- Drives the gate pool operand inputs, captures the selected result, and streams it back as bytes to the UART transmitter.
- Sits between the UART RX/TX byte interfaces and the gate pool.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 8; NB = WIDTH/8.
TIMEOUT_CYC, 100000, maximum idle cycles between bytes inside a frame before the frame is aborted; must be ≥ 2.

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe: i_rx_data valid
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data valid, held until accepted
i_tx_ready  in  1  transmitter accepts byte when o_tx_valid & i_tx_ready
o_not_in  out  WIDTH  gate pool NOT operand (= A register)
o_or_a  out  WIDTH  gate pool OR operand 0 (= A)
o_or_b  out  WIDTH  gate pool OR operand 1 (= B)
o_and_a  out  WIDTH  gate pool AND operand 0 (= A)
o_and_b  out  WIDTH  gate pool AND operand 1 (= B)
i_res_not  in  WIDTH  gate pool NOT result
i_res_or  in  WIDTH  gate pool OR result
i_res_and  in  WIDTH  gate pool AND result
o_busy  out  1  high in any state other than IDLE
o_rx_drop  out  1  one-cycle pulse: byte received while not accepting
o_timeout  out  1  one-cycle pulse: frame aborted on inter-byte timeout

Behaviour:
- Reset, asynchronous and active-low: state = IDLE. A, B, opcode, result shift register, byte counter, and timeout counter = 0. o_tx_data = 0; o_tx_valid, o_busy, o_rx_drop, o_timeout = 0. Reset mid-frame or mid-send abandons everything; no partial byte is emitted afterwards.
- Frame format: 1 opcode byte, then NB bytes of A, then NB bytes of B, each operand LSB byte first.
- Opcodes: 0x00 selects NOT, 0x01 OR, 0x02 AND. Any other value is invalid.
- IDLE, on i_rx_valid:
  - Valid opcode: latch it, go to GET_A, byte counter = 0.
  - Invalid opcode: go to ERR.
- GET_A / GET_B: each i_rx_valid writes the byte into lane [counter] of A (resp. B) and increments the counter. After lane NB-1, GET_A→GET_B (counter cleared) and GET_B→EXEC.
- Timeout: counter clears on every accepted byte and increments on every other cycle in GET_A/GET_B. When it reaches TIMEOUT_CYC-1 with no byte that cycle:
  - go to IDLE, pulse o_timeout;
  - A/B keep their partially written values.
- Operand outputs are direct copies of the A/B registers in all states (registered, glitch-free).
- EXEC: one settle cycle, then CAPTURE.
- CAPTURE: load the shift register from i_res_not/i_res_or/i_res_and per opcode, then SEND. Result latency: first o_tx_valid appears 2 cycles after the final B byte strobe.
- SEND:
  - o_tx_valid = 1, o_tx_data = shift register [7:0].
  - On valid&ready: shift right 8 and increment the counter. After the NB-th acceptance, o_tx_valid = 0 the next cycle and state = IDLE.
  - o_tx_data is stable while valid and not ready.
- ERR: o_tx_valid = 1, o_tx_data = 0xEE until accepted, then IDLE.
- i_rx_valid in EXEC, CAPTURE, SEND, or ERR: byte discarded, o_rx_drop pulses for one cycle, state unaffected.
- A new opcode is accepted in the same cycle IDLE is re-entered only from the cycle after SEND/ERR completes (i.e. the first IDLE cycle).
- No timeout in SEND: backpressure may stall indefinitely.

Test Plan:
- The bench drives the pool ports with a behavioural NOT/OR/AND model.
- NOT, WIDTH=32: bytes 00, 78 56 34 12, 00 00 00 00 -> o_not_in = 0x12345678; tx bytes 87 A9 CB ED; first o_tx_valid 2 cycles after last strobe; o_busy low after the 4th handshake.
- OR with backpressure: 01, 0F 00 00 00, F0 00 00 01, i_tx_ready low for 5 cycles then toggling every other cycle -> tx bytes FF 00 00 01, each byte held stable while not ready.
- AND: 02, FF FF 00 00, 0F 0F 0F 0F -> tx bytes 0F 0F 00 00.
- Invalid opcode 0x07 -> single tx byte EE, then IDLE. Extra byte sent during ERR -> o_rx_drop pulses once, and no second frame starts.
- Timeout with TIMEOUT_CYC=16: 01, 11 22, then silence -> o_timeout pulses 16 cycles after byte 22, state IDLE. A following full OR frame 01, 01 00 00 00, 02 00 00 00 -> tx 03 00 00 00.
- Reset: assert i_rst_n low mid-SEND after 1 of 4 bytes -> all outputs 0 immediately. After release, no further tx bytes, and a new NOT frame returns correct results.
